alarm_input_ctrl: RTL and testbench

ALARM_INPUT_CTRL -- requirements
Module: alarm_input_ctrl

---
 rtl/alarm_pkg.sv | 19 +
 rtl/sensor_debounce.sv | 47 ++++
 rtl/alarm_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_alarm_input_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared entry-FSM encoding and default parameters for alarm_input_ctrl
package alarm_pkg;

  // Keypad entry FSM: three digit-holding states, then compare on the fourth key
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_LOCK = 3'd4
  } entry_state_t;

  localparam int          DEF_DEB_CYCLES  = 4;
  localparam logic [15:0] DEF_CODE        = 16'h1234;
  localparam int          DEF_MAX_ERR     = 3;
  localparam int          DEF_LOCK_CYCLES = 16;
  localparam int          DEF_TIMEOUT     = 32;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer plus stability counter for the intrusion sensor
module sensor_debounce
  import alarm_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic sensor_db
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous sensor into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the held level for DEB_CYCLES cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sensor_db <= 1'b0;
    end else if (sync2 == sensor_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      sensor_db <= sync2;
      cnt       <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_input_ctrl.sv
// rtl/alarm_input_ctrl.sv - keypad arm/disarm with lockout and debounced, arm-gated sensor trigger
module alarm_input_ctrl
  import alarm_pkg::*;
#(
  parameter int          DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter logic [15:0] CODE        = DEF_CODE,
  parameter int          MAX_ERR     = DEF_MAX_ERR,
  parameter int          LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       T,
  output logic       armed,
  output logic       code_err,
  output logic       locked
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int EW = $clog2(MAX_ERR + 1);

  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_MAX   = TW'(TIMEOUT);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_CYCLES);
  localparam logic [EW-1:0] ERR_LAST  = EW'(MAX_ERR - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(MAX_ERR);

  entry_state_t  state;
  logic [3:0]    d0, d1, d2;
  logic [TW-1:0] idle_tmr;
  logic [LW-1:0] lock_cnt;
  logic [EW-1:0] err_cnt;
  logic          sensor_db;

  logic          timed_out;
  logic [TW-1:0] tmr_inc;
  logic [LW-1:0] lock_inc;
  logic [EW-1:0] err_inc;
  logic          code_match;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .sensor   (sensor),
    .sensor_db(sensor_db)
  );

  assign timed_out  = (idle_tmr == TMR_LAST);
  assign tmr_inc    = (idle_tmr == TMR_MAX) ? idle_tmr : idle_tmr + 1'b1;
  assign lock_inc   = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  assign err_inc    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
  assign code_match = ({d0, d1, d2, key_code} == CODE);

  // Trigger follows the registered armed flag, so disarming drops T one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      T <= 1'b0;
    end else begin
      T <= armed & sensor_db;
    end
  end

  // Code entry FSM with digit storage, idle timeout, error counting and lockout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      d0       <= 4'd0;
      d1       <= 4'd0;
      d2       <= 4'd0;
      idle_tmr <= '0;
      lock_cnt <= '0;
      err_cnt  <= '0;
      armed    <= 1'b0;
      code_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      code_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_tmr <= '0;
          if (key_valid) begin
            d0    <= key_code;
            state <= ST_D1;
          end
        end
        ST_D1, ST_D2, ST_D3: begin
          if (key_valid) begin
            idle_tmr <= '0;
            if (state == ST_D1) begin
              d1    <= key_code;
              state <= ST_D2;
            end else if (state == ST_D2) begin
              d2    <= key_code;
              state <= ST_D3;
            end else begin
              state <= ST_IDLE;
              d0    <= 4'd0;
              d1    <= 4'd0;
              d2    <= 4'd0;
              if (code_match) begin
                armed   <= ~armed;
                err_cnt <= '0;
              end else begin
                code_err <= 1'b1;
                if (err_cnt == ERR_LAST) begin
                  err_cnt  <= '0;
                  lock_cnt <= '0;
                  locked   <= 1'b1;
                  state    <= ST_LOCK;
                end else begin
                  err_cnt <= err_inc;
                end
              end
            end
          end else if (timed_out) begin
            // Abandoned partial entry: drop digits without counting it as an error
            state    <= ST_IDLE;
            idle_tmr <= '0;
            d0       <= 4'd0;
            d1       <= 4'd0;
            d2       <= 4'd0;
          end else begin
            idle_tmr <= tmr_inc;
          end
        end
        ST_LOCK: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            lock_cnt <= lock_inc;
          end
        end
        default: begin
          state  <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_input_ctrl.sv
// tb/tb_alarm_input_ctrl.sv - directed self-checking bench for alarm_input_ctrl
module tb_alarm_input_ctrl;

  logic       clk;
  logic       reset;
  logic       sensor;
  logic       key_valid;
  logic [3:0] key_code;
  logic       T;
  logic       armed;
  logic       code_err;
  logic       locked;

  int pass_cnt;
  int total_cnt;

  alarm_input_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .sensor   (sensor),
    .key_valid(key_valid),
    .key_code (key_code),
    .T        (T),
    .armed    (armed),
    .code_err (code_err),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    sensor    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input logic [3:0] d);
    key_code  = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    sensor    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    tick();
    total_cnt++;
    if ({T, armed, code_err, locked} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {T, armed, code_err, locked});
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sensor_latency();
    logic seen_t;
    do_reset();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL latency_armed: got %b expected 1", armed);
    else pass_cnt++;
    sensor = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total_cnt++;
      if (T !== 1'b0) $display("FAIL latency_early_edge%0d: got %b expected 0", i - 1, T);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (T !== 1'b1) $display("FAIL latency_edge6: got %b expected 1", T);
    else pass_cnt++;
    repeat (3) tick();
    sensor = 1'b0;
    repeat (10) tick();
    total_cnt++;
    if (T !== 1'b0) $display("FAIL sensor_release: got %b expected 0", T);
    else pass_cnt++;
    seen_t = 1'b0;
    sensor = 1'b1;
    repeat (3) begin
      tick();
      seen_t |= T;
    end
    sensor = 1'b0;
    repeat (12) begin
      tick();
      seen_t |= T;
    end
    total_cnt++;
    if (seen_t !== 1'b0) $display("FAIL glitch_3cyc: got T high %b expected 0", seen_t);
    else pass_cnt++;
  endtask

  task automatic test_arm_disarm();
    do_reset();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    total_cnt++;
    if (armed !== 1'b0) $display("FAIL arm_before_4th: got %b expected 0", armed);
    else pass_cnt++;
    press(4'd4);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL arm_at_4th: got %b expected 1", armed);
    else pass_cnt++;
    sensor = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (T !== 1'b1) $display("FAIL armed_sensor_T: got %b expected 1", T);
    else pass_cnt++;
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if ({armed, T} !== 2'b01) $display("FAIL disarm_edge: got armed,T=%b expected 01", {armed, T});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (T !== 1'b0) $display("FAIL disarm_T_next: got %b expected 0", T);
    else pass_cnt++;
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if ({armed, T} !== 2'b10) $display("FAIL rearm_edge: got armed,T=%b expected 10", {armed, T});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (T !== 1'b1) $display("FAIL rearm_T_next: got %b expected 1", T);
    else pass_cnt++;
    sensor = 1'b0;
  endtask

  task automatic test_lockout();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(4'd1, 4'd2, 4'd3, 4'd5);
      total_cnt++;
      if (code_err !== 1'b1) $display("FAIL wrong_code_err%0d: got %b expected 1", k, code_err);
      else pass_cnt++;
      total_cnt++;
      if (locked !== (k == 2)) $display("FAIL locked_after_err%0d: got %b expected %b", k, locked, (k == 2));
      else pass_cnt++;
      if (k < 2) begin
        tick();
        total_cnt++;
        if (code_err !== 1'b0) $display("FAIL code_err_pulse%0d: got %b expected 0", k, code_err);
        else pass_cnt++;
      end
    end
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if ({armed, code_err, locked} !== 3'b001)
      $display("FAIL keys_in_lock: got armed,err,locked=%b expected 001", {armed, code_err, locked});
    else pass_cnt++;
    repeat (11) tick();
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL lock_cycle15: got %b expected 1", locked);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL lock_cycle16: got %b expected 0", locked);
    else pass_cnt++;
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL arm_after_lock: got %b expected 1", armed);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic err_early;
    do_reset();
    press(4'd1);
    press(4'd2);
    repeat (32) tick();
    err_early = 1'b0;
    press(4'd3);
    err_early |= code_err;
    press(4'd4);
    err_early |= code_err | armed;
    press(4'd1);
    err_early |= code_err;
    total_cnt++;
    if (err_early !== 1'b0) $display("FAIL timeout_restart_early: got %b expected 0", err_early);
    else pass_cnt++;
    press(4'd2);
    total_cnt++;
    if ({armed, code_err} !== 2'b01)
      $display("FAIL timeout_restart_err: got armed,err=%b expected 01", {armed, code_err});
    else pass_cnt++;
    press(4'd1);
    repeat (31) tick();
    press(4'd2);
    press(4'd3);
    press(4'd4);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL key_at_timeout_edge: got %b expected 1", armed);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    sensor = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if ({T, armed} !== 2'b11) $display("FAIL pre_reset_armed: got T,armed=%b expected 11", {T, armed});
    else pass_cnt++;
    press(4'd1);
    press(4'd2);
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({T, armed, code_err, locked} !== 4'b0000)
      $display("FAIL async_reset_entry: got %b expected 0000", {T, armed, code_err, locked});
    else pass_cnt++;
    sensor = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL arm_after_entry_reset: got %b expected 1", armed);
    else pass_cnt++;
    do_reset();
    repeat (3) enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    press(4'd1);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL pre_reset_locked: got %b expected 1", locked);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({T, armed, code_err, locked} !== 4'b0000)
      $display("FAIL async_reset_lock: got %b expected 0000", {T, armed, code_err, locked});
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    total_cnt++;
    if ({armed, locked} !== 2'b10) $display("FAIL arm_after_lock_reset: got armed,locked=%b expected 10", {armed, locked});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_sensor_latency();
    test_arm_disarm();
    test_lockout();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
